// File: rtl/csr_trap_seq_if.sv
// CSR trap sequencer bus: pipeline retire events, CSR read-back values,
// the pipeline's own CSR write request, and everything the sequencer
// drives back (CSR write port, stall, redirect, sticky error).
interface csr_trap_seq_if #(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
);
    logic              trap_req_i;
    logic              mret_req_i;
    logic [XLEN-1:0]   trap_pc_i;
    logic [XLEN-1:0]   mstatus_i;
    logic [XLEN-1:0]   mtvec_i;
    logic [XLEN-1:0]   mepc_i;
    logic              pipe_csr_we_i;
    logic [CSR_AW-1:0] pipe_csr_addr_i;
    logic [XLEN-1:0]   pipe_csr_wdata_i;
    logic              csr_we_o;
    logic [CSR_AW-1:0] csr_addr_o;
    logic [XLEN-1:0]   csr_wdata_o;
    logic              stall_o;
    logic              redirect_valid_o;
    logic [XLEN-1:0]   redirect_pc_o;
    logic              err_o;

    // Pipeline / CSR file side
    modport master (
        output trap_req_i, mret_req_i, trap_pc_i, mstatus_i, mtvec_i, mepc_i,
               pipe_csr_we_i, pipe_csr_addr_i, pipe_csr_wdata_i,
        input  csr_we_o, csr_addr_o, csr_wdata_o, stall_o,
               redirect_valid_o, redirect_pc_o, err_o
    );

    // Sequencer side
    modport slave (
        input  trap_req_i, mret_req_i, trap_pc_i, mstatus_i, mtvec_i, mepc_i,
               pipe_csr_we_i, pipe_csr_addr_i, pipe_csr_wdata_i,
        output csr_we_o, csr_addr_o, csr_wdata_o, stall_o,
               redirect_valid_o, redirect_pc_o, err_o
    );
endinterface

// File: rtl/csr_trap_seq.sv
// Trap/return sequencer for the machine-mode CSR file write port.
// Serialises the ecall (mepc, mcause, mstatus) and mret (mstatus) CSR
// updates one write per cycle, then emits a one-cycle PC redirect.
// Ordinary CSR-instruction writes pass straight through while idle.
// Optional feature macro: CSR_TRAP_MSTATUS_EN (adds the mstatus write step).
module csr_trap_seq #(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic          clk_i,
    input  logic          rst,
    csr_trap_seq_if.slave bus
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] W_MEPC    = 3'd1;
    localparam logic [2:0] W_MCAUSE  = 3'd2;
`ifdef CSR_TRAP_MSTATUS_EN
    localparam logic [2:0] W_MSTATUS = 3'd3;
`endif
    localparam logic [2:0] REDIRECT  = 3'd4;

    localparam logic KIND_TRAP = 1'b0;
    localparam logic KIND_RET  = 1'b1;

    localparam logic [CSR_AW-1:0] ADDR_MSTATUS = CSR_AW'(12'h300);
    localparam logic [CSR_AW-1:0] ADDR_MEPC    = CSR_AW'(12'h341);
    localparam logic [CSR_AW-1:0] ADDR_MCAUSE  = CSR_AW'(12'h342);
    localparam logic [XLEN-1:0]   CAUSE_ECALL_M = XLEN'(32'h0000_000B);

    logic [2:0]      state_q;
    logic            kind_q;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] target_q;
    logic            err_q;

`ifdef CSR_TRAP_MSTATUS_EN
    logic [XLEN-1:0] mstatus_q;
    logic [XLEN-1:0] mstatus_new;

    // Next mstatus: trap stacks MIE into MPIE, return unstacks it; MPP is always M
    always_comb begin
        mstatus_new = mstatus_q;
        if (kind_q == KIND_TRAP) begin
            mstatus_new[7] = mstatus_q[3];
            mstatus_new[3] = 1'b0;
        end else begin
            mstatus_new[3] = mstatus_q[7];
            mstatus_new[7] = 1'b1;
        end
        mstatus_new[12:11] = 2'b11;
    end
`else
    logic unused_mstatus;
    assign unused_mstatus = ^bus.mstatus_i;
`endif

    // Sequencer state, latched operands and the sticky busy-write error
    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q  <= IDLE;
            kind_q   <= KIND_TRAP;
            epc_q    <= '0;
            target_q <= '0;
            err_q    <= 1'b0;
`ifdef CSR_TRAP_MSTATUS_EN
            mstatus_q <= '0;
`endif
        end else begin
            if (state_q != IDLE && bus.pipe_csr_we_i) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (bus.trap_req_i) begin
                        kind_q   <= KIND_TRAP;
                        epc_q    <= bus.trap_pc_i;
                        target_q <= bus.mtvec_i;
`ifdef CSR_TRAP_MSTATUS_EN
                        mstatus_q <= bus.mstatus_i;
`endif
                        state_q  <= W_MEPC;
                    end else if (bus.mret_req_i) begin
                        kind_q   <= KIND_RET;
                        target_q <= bus.mepc_i;
`ifdef CSR_TRAP_MSTATUS_EN
                        mstatus_q <= bus.mstatus_i;
                        state_q   <= W_MSTATUS;
`else
                        state_q   <= REDIRECT;
`endif
                    end
                end
                W_MEPC:    state_q <= W_MCAUSE;
`ifdef CSR_TRAP_MSTATUS_EN
                W_MCAUSE:  state_q <= W_MSTATUS;
                W_MSTATUS: state_q <= REDIRECT;
`else
                W_MCAUSE:  state_q <= REDIRECT;
`endif
                REDIRECT:  state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end

    // CSR write port: pipeline pass-through when idle, sequencer writes otherwise
    always_comb begin
        bus.csr_we_o    = 1'b0;
        bus.csr_addr_o  = '0;
        bus.csr_wdata_o = '0;
        case (state_q)
            IDLE: begin
                bus.csr_we_o    = bus.pipe_csr_we_i;
                bus.csr_addr_o  = bus.pipe_csr_addr_i;
                bus.csr_wdata_o = bus.pipe_csr_wdata_i;
            end
            W_MEPC: begin
                bus.csr_we_o    = 1'b1;
                bus.csr_addr_o  = ADDR_MEPC;
                bus.csr_wdata_o = epc_q;
            end
            W_MCAUSE: begin
                bus.csr_we_o    = 1'b1;
                bus.csr_addr_o  = ADDR_MCAUSE;
                bus.csr_wdata_o = CAUSE_ECALL_M;
            end
`ifdef CSR_TRAP_MSTATUS_EN
            W_MSTATUS: begin
                bus.csr_we_o    = 1'b1;
                bus.csr_addr_o  = ADDR_MSTATUS;
                bus.csr_wdata_o = mstatus_new;
            end
`endif
            default: begin
                bus.csr_we_o    = 1'b0;
                bus.csr_addr_o  = '0;
                bus.csr_wdata_o = '0;
            end
        endcase
    end

    // Stall, redirect and error outputs; trap vectors are forced to direct mode
    always_comb begin
        bus.stall_o          = (state_q != IDLE) | bus.trap_req_i | bus.mret_req_i;
        bus.redirect_valid_o = (state_q == REDIRECT);
        bus.redirect_pc_o    = (kind_q == KIND_TRAP) ? {target_q[XLEN-1:2], 2'b00} : target_q;
        bus.err_o            = err_q;
    end

endmodule

// File: tb/tb_csr_trap_seq.sv
// Directed testbench for csr_trap_seq. Expectations follow the build:
// define CSR_TRAP_MSTATUS_EN for both DUT and bench to test the mstatus step.
module tb_csr_trap_seq;

    logic clk_i = 1'b0;
    logic rst   = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    csr_trap_seq_if #(.XLEN(32), .CSR_AW(12)) bus ();

    csr_trap_seq #(.XLEN(32), .CSR_AW(12)) dut (
        .clk_i (clk_i),
        .rst   (rst),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic trap, input logic mret,
                                 input logic [31:0] pc, input logic [31:0] tvec,
                                 input logic [31:0] epc, input logic [31:0] ms);
        bus.trap_req_i = trap;
        bus.mret_req_i = mret;
        bus.trap_pc_i  = pc;
        bus.mtvec_i    = tvec;
        bus.mepc_i     = epc;
        bus.mstatus_i  = ms;
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        bus.pipe_csr_we_i    = 1'b0;
        bus.pipe_csr_addr_i  = '0;
        bus.pipe_csr_wdata_i = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.csr_we_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset csr_we: got %0b expected 0", bus.csr_we_o);
        end
        checks++;
        if (bus.stall_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset stall: got %0b expected 0", bus.stall_o);
        end
        checks++;
        if (bus.redirect_valid_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset redirect_valid: got %0b expected 0", bus.redirect_valid_o);
        end
        checks++;
        if (bus.err_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset err: got %0b expected 0", bus.err_o);
        end
    endtask

    // Trap sequence, optionally with a simultaneous mret that must lose
    task automatic test_trap(input logic with_mret);
        logic        e_we    [0:5];
        logic [11:0] e_addr  [0:5];
        logic [31:0] e_data  [0:5];
        logic        e_rv    [0:5];
        logic        e_stall [0:5];
        string       tag;
        tag = with_mret ? "trap+mret" : "trap";
        for (int i = 0; i < 6; i++) begin
            e_we[i] = 1'b0; e_addr[i] = '0; e_data[i] = '0; e_rv[i] = 1'b0; e_stall[i] = 1'b0;
        end
        e_stall[0] = 1'b1;
        e_we[1] = 1'b1; e_addr[1] = 12'h341; e_data[1] = 32'h80; e_stall[1] = 1'b1;
        e_we[2] = 1'b1; e_addr[2] = 12'h342; e_data[2] = 32'hB;  e_stall[2] = 1'b1;
`ifdef CSR_TRAP_MSTATUS_EN
        e_we[3] = 1'b1; e_addr[3] = 12'h300; e_data[3] = 32'h1880; e_stall[3] = 1'b1;
        e_rv[4] = 1'b1; e_stall[4] = 1'b1;
`else
        e_rv[3] = 1'b1; e_stall[3] = 1'b1;
`endif
        applyStimulus(1'b1, with_mret, 32'h80, 32'h103, 32'h5554, 32'h1808);
        #1;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (bus.stall_o !== e_stall[c]) begin
                failures++;
                $display("[TB] FAIL %s c%0d stall: got %0b expected %0b", tag, c, bus.stall_o, e_stall[c]);
            end
            checks++;
            if (bus.csr_we_o !== e_we[c]) begin
                failures++;
                $display("[TB] FAIL %s c%0d csr_we: got %0b expected %0b", tag, c, bus.csr_we_o, e_we[c]);
            end
            if (e_we[c]) begin
                checks++;
                if (bus.csr_addr_o !== e_addr[c] || bus.csr_wdata_o !== e_data[c]) begin
                    failures++;
                    $display("[TB] FAIL %s c%0d write: got (%h,%h) expected (%h,%h)", tag, c,
                             bus.csr_addr_o, bus.csr_wdata_o, e_addr[c], e_data[c]);
                end
            end
            checks++;
            if (bus.redirect_valid_o !== e_rv[c]) begin
                failures++;
                $display("[TB] FAIL %s c%0d redirect_valid: got %0b expected %0b", tag, c, bus.redirect_valid_o, e_rv[c]);
            end
            if (e_rv[c]) begin
                checks++;
                if (bus.redirect_pc_o !== 32'h100) begin
                    failures++;
                    $display("[TB] FAIL %s c%0d redirect_pc: got %h expected 00000100", tag, c, bus.redirect_pc_o);
                end
            end
            tick();
            applyStimulus(1'b0, 1'b0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
            #1;
        end
    endtask

    task automatic test_ret();
        logic        e_we [0:3];
        logic        e_rv [0:3];
        logic        e_stall [0:3];
        for (int i = 0; i < 4; i++) begin
            e_we[i] = 1'b0; e_rv[i] = 1'b0; e_stall[i] = 1'b0;
        end
        e_stall[0] = 1'b1;
`ifdef CSR_TRAP_MSTATUS_EN
        e_we[1] = 1'b1; e_stall[1] = 1'b1;
        e_rv[2] = 1'b1; e_stall[2] = 1'b1;
`else
        e_rv[1] = 1'b1; e_stall[1] = 1'b1;
`endif
        applyStimulus(1'b0, 1'b1, 32'h4444, 32'h7777, 32'h84, 32'h1880);
        #1;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (bus.stall_o !== e_stall[c]) begin
                failures++;
                $display("[TB] FAIL ret c%0d stall: got %0b expected %0b", c, bus.stall_o, e_stall[c]);
            end
            checks++;
            if (bus.csr_we_o !== e_we[c]) begin
                failures++;
                $display("[TB] FAIL ret c%0d csr_we: got %0b expected %0b", c, bus.csr_we_o, e_we[c]);
            end
            if (e_we[c]) begin
                checks++;
                if (bus.csr_addr_o !== 12'h300 || bus.csr_wdata_o !== 32'h1888) begin
                    failures++;
                    $display("[TB] FAIL ret c%0d write: got (%h,%h) expected (300,00001888)", c,
                             bus.csr_addr_o, bus.csr_wdata_o);
                end
            end
            checks++;
            if (bus.redirect_valid_o !== e_rv[c]) begin
                failures++;
                $display("[TB] FAIL ret c%0d redirect_valid: got %0b expected %0b", c, bus.redirect_valid_o, e_rv[c]);
            end
            if (e_rv[c]) begin
                checks++;
                if (bus.redirect_pc_o !== 32'h84) begin
                    failures++;
                    $display("[TB] FAIL ret c%0d redirect_pc: got %h expected 00000084", c, bus.redirect_pc_o);
                end
            end
            tick();
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'hDEAD_BEEC, 32'h0);
            #1;
        end
    endtask

    task automatic test_passthrough();
        bus.pipe_csr_we_i    = 1'b1;
        bus.pipe_csr_addr_i  = 12'h305;
        bus.pipe_csr_wdata_i = 32'h200;
        #1;
        checks++;
        if (bus.csr_we_o !== 1'b1 || bus.csr_addr_o !== 12'h305 || bus.csr_wdata_o !== 32'h200) begin
            failures++;
            $display("[TB] FAIL passthrough idle: got (%0b,%h,%h) expected (1,305,00000200)",
                     bus.csr_we_o, bus.csr_addr_o, bus.csr_wdata_o);
        end
        checks++;
        if (bus.stall_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL passthrough stall: got %0b expected 0", bus.stall_o);
        end
        applyStimulus(1'b1, 1'b0, 32'h80, 32'h100, 32'h0, 32'h0);
        #1;
        checks++;
        if (bus.csr_we_o !== 1'b1 || bus.csr_addr_o !== 12'h305 || bus.csr_wdata_o !== 32'h200) begin
            failures++;
            $display("[TB] FAIL passthrough accept: got (%0b,%h,%h) expected (1,305,00000200)",
                     bus.csr_we_o, bus.csr_addr_o, bus.csr_wdata_o);
        end
        checks++;
        if (bus.stall_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL passthrough accept stall: got %0b expected 1", bus.stall_o);
        end
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        bus.pipe_csr_we_i = 1'b0;
        repeat (5) tick();
        checks++;
        if (bus.err_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL passthrough err: got %0b expected 0", bus.err_o);
        end
    endtask

    task automatic test_error();
        applyStimulus(1'b1, 1'b0, 32'h80, 32'h100, 32'h0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        bus.pipe_csr_we_i    = 1'b1;
        bus.pipe_csr_addr_i  = 12'h305;
        bus.pipe_csr_wdata_i = 32'h200;
        #1;
        checks++;
        if (bus.csr_addr_o !== 12'h342 || bus.csr_wdata_o !== 32'hB) begin
            failures++;
            $display("[TB] FAIL error drop: got (%h,%h) expected (342,0000000b)", bus.csr_addr_o, bus.csr_wdata_o);
        end
        tick();
        bus.pipe_csr_we_i = 1'b0;
        #1;
        checks++;
        if (bus.err_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL error set: got %0b expected 1", bus.err_o);
        end
        repeat (5) tick();
        checks++;
        if (bus.err_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL error sticky: got %0b expected 1", bus.err_o);
        end
    endtask

    task automatic test_reset_mid();
        applyStimulus(1'b1, 1'b0, 32'h80, 32'h100, 32'h0, 32'h1808);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.csr_we_o !== 1'b0 || bus.redirect_valid_o !== 1'b0 || bus.stall_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid c3: got (we %0b, rv %0b, stall %0b) expected (0,0,0)",
                     bus.csr_we_o, bus.redirect_valid_o, bus.stall_o);
        end
        checks++;
        if (bus.err_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid err: got %0b expected 0", bus.err_o);
        end
        tick();
        checks++;
        if (bus.csr_we_o !== 1'b0 || bus.redirect_valid_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid c4: got (we %0b, rv %0b) expected (0,0)",
                     bus.csr_we_o, bus.redirect_valid_o);
        end
    endtask

    // mret accepted in the cycle right after a trap redirect
    task automatic test_back_to_back();
        int redir_cycle;
`ifdef CSR_TRAP_MSTATUS_EN
        redir_cycle = 4;
`else
        redir_cycle = 3;
`endif
        applyStimulus(1'b1, 1'b0, 32'h80, 32'h100, 32'h0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        repeat (redir_cycle - 1) tick();
        checks++;
        if (bus.redirect_valid_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b trap redirect: got %0b expected 1", bus.redirect_valid_o);
        end
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 32'h200, 32'h0);
        #1;
        checks++;
        if (bus.stall_o !== 1'b1 || bus.redirect_valid_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b accept: got (stall %0b, rv %0b) expected (1,0)", bus.stall_o, bus.redirect_valid_o);
        end
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
`ifdef CSR_TRAP_MSTATUS_EN
        checks++;
        if (bus.csr_we_o !== 1'b1 || bus.csr_addr_o !== 12'h300 || bus.csr_wdata_o !== 32'h1880) begin
            failures++;
            $display("[TB] FAIL b2b mstatus: got (%0b,%h,%h) expected (1,300,00001880)",
                     bus.csr_we_o, bus.csr_addr_o, bus.csr_wdata_o);
        end
        tick();
`endif
        checks++;
        if (bus.redirect_valid_o !== 1'b1 || bus.redirect_pc_o !== 32'h200) begin
            failures++;
            $display("[TB] FAIL b2b ret redirect: got (%0b,%h) expected (1,00000200)",
                     bus.redirect_valid_o, bus.redirect_pc_o);
        end
        tick();
        checks++;
        if (bus.stall_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b final stall: got %0b expected 0", bus.stall_o);
        end
    endtask

    initial begin
        $display("[TB] csr_trap_seq directed test start");
        test_reset();
        test_trap(1'b0);
        test_ret();
        test_trap(1'b1);
        test_passthrough();
        test_error();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_trap_seq.md
# csr_trap_seq

Trap/return sequencer that drives the write side of the machine-mode CSR file. It accepts `ecall` and `mret` events from the pipeline, latches the CSR values it needs, and issues one CSR write per cycle in a fixed order, because the CSR file accepts only one write per cycle. It then emits a single-cycle PC redirect. It sits between the pipeline's CSR write path and the CSR file, and muxes ordinary CSR-instruction writes through when idle.

## Interface
- `XLEN`, 32, data width of CSR values and PCs
- `CSR_AW`, 12, CSR address width
- `clk_i`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `trap_req_i`  in  1  `ecall` retiring this cycle
- `mret_req_i`  in  1  `mret` retiring this cycle
- `trap_pc_i`  in  XLEN  PC of the retiring `ecall`
- `mstatus_i`, `mtvec_i`, `mepc_i`  in  XLEN each  current CSR contents, read-back from the CSR file
- `pipe_csr_we_i`, `pipe_csr_addr_i` (CSR_AW), `pipe_csr_wdata_i` (XLEN)  in  write request from a CSR instruction
- `csr_we_o`  out  1  write strobe to the CSR file
- `csr_addr_o`  out  CSR_AW  write address
- `csr_wdata_o`  out  XLEN  write data
- `stall_o`  out  1  holds the pipeline front end
- `redirect_valid_o`  out  1  single-cycle PC redirect strobe
- `redirect_pc_o`  out  XLEN  redirect target
- `err_o`  out  1  sticky; set when a pipeline write arrives while busy

## Operation
- States: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, REDIRECT.
- IDLE, `trap_req_i`=1:
  - Latch `trap_pc_i`, `mtvec_i`, `mstatus_i`.
  - Set kind = TRAP and go to W_MEPC.
  - Takes priority over a simultaneous `mret_req_i`.
- IDLE, `mret_req_i`=1 (no trap):
  - Latch `mepc_i`, `mstatus_i`.
  - Set kind = RET and go to W_MSTATUS.
- W_MEPC: write 0x341 = latched PC, then go to W_MCAUSE.
- W_MCAUSE: write 0x342 = 32'h0000_000B, then go to W_MSTATUS.
- W_MSTATUS: write 0x300 = new mstatus (bits below), then go to REDIRECT.
  - TRAP: MPIE[7] ← MIE[3]; MIE[3] ← 0; MPP[12:11] ← 2'b11; all other bits unchanged.
  - RET: MIE[3] ← MPIE[7]; MPIE[7] ← 1; MPP[12:11] ← 2'b11 (M-only core); all other bits unchanged.
- REDIRECT:
  - `redirect_valid_o`=1.
  - `redirect_pc_o` = latched mtvec with bits [1:0] forced to 0 (TRAP), or latched mepc (RET).
  - Go to IDLE.
- Pass-through in IDLE: `csr_*_o` mirror the `pipe_csr_*_i` inputs combinationally, including in the accept cycle.
- Busy (state ≠ IDLE):
  - Pipeline writes are dropped.
  - If `pipe_csr_we_i`=1, `err_o` ← 1 and stays set until reset.
- Requests arriving while busy are ignored; the pipeline is stalled, so none are expected.
- Non-IDLE states drive `csr_*_o` from registers. The REDIRECT state drives `csr_we_o`=0.

## Timing
- Reset values: state IDLE, all latches 0, `err_o`=0.
  - `csr_we_o`, `redirect_valid_o`, `stall_o` are 0 unless the pipeline inputs are active in IDLE.
- `stall_o` = (state≠IDLE) | `trap_req_i` | `mret_req_i`. It is combinational, so it rises in the accept cycle.
- TRAP accepted in cycle 0:
  - mepc written in cycle 1, mcause in cycle 2, mstatus in cycle 3.
  - Redirect in cycle 4; `stall_o` drops in cycle 5.
- RET accepted in cycle 0: mstatus written in cycle 1, redirect in cycle 2.
- Write data always comes from values latched at accept. Later changes on `*_i` have no effect.
- Reset asserted mid-sequence: next cycle is IDLE, with no further writes and no redirect.
- Back-to-back: a new request may be accepted in the cycle after REDIRECT.

## Configuration
- `CSR_TRAP_MSTATUS_EN` defined:
  - W_MSTATUS is present and behaves as above.
  - Trap latency is 4 cycles to redirect; RET latency is 2.
- `CSR_TRAP_MSTATUS_EN` undefined:
  - W_MSTATUS is removed and mstatus is never written.
  - TRAP goes W_MEPC → W_MCAUSE → REDIRECT (redirect in cycle 3).
  - RET goes directly to REDIRECT (redirect in cycle 1).
  - The `mstatus_i` latch is not built.

## Test plan
- Trap:
  - Stimulus: `trap_pc_i`=0x80, `mtvec_i`=0x103, `mstatus_i`=0x1808, with `trap_req_i` pulsed.
  - Required writes: (0x341, 0x80) in cycle 1, (0x342, 0xB) in cycle 2, (0x300, 0x1880) in cycle 3.
  - Required redirect: pc 0x100 in cycle 4; `stall_o` high in cycles 0–4.
- Return:
  - Stimulus: `mepc_i`=0x84, `mstatus_i`=0x1880, with `mret_req_i` pulsed.
  - Required: (0x300, 0x1888) in cycle 1, redirect 0x84 in cycle 2.
- Simultaneous `trap_req_i`=`mret_req_i`=1 → the TRAP sequence only.
- Pass-through and error:
  - In IDLE, pipeline write (0x305, 0x200) appears on `csr_*_o` in the same cycle.
  - The same write issued in W_MCAUSE is dropped and `err_o`=1.
- Reset asserted in W_MCAUSE → IDLE next cycle, with no mstatus write and no redirect.
- Without `CSR_TRAP_MSTATUS_EN`:
  - Trap redirect occurs in cycle 3 and no 0x300 write is seen.
  - `mret` redirect occurs in cycle 1.
